// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Control/status bundle between the fetch control logic and the
//               program-counter sequencer.
//               master : drives stall/branch/jump/call/ret/imm, observes PC and
//                        the return-address-stack status.
//               slave  : the sequencer itself.
// Signals     : stall, branch, jump, call, ret  - control requests
//               imm [IMM_W]                     - offset or absolute target
//               PC  [PC_W]                      - current fetch address
//               sp  [clog2(RAS_DEPTH+1)]        - valid stack entries
//               ras_full, ras_empty, ras_err    - stack status
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
  parameter int PC_W      = 8,
  parameter int IMM_W     = 8,
  parameter int RAS_DEPTH = 4
) ();
  localparam int SP_W = $clog2(RAS_DEPTH + 1);

  logic              stall;
  logic              branch;
  logic              jump;
  logic              call;
  logic              ret;
  logic [IMM_W-1:0]  imm;
  logic [PC_W-1:0]   PC;
  logic [SP_W-1:0]   sp;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_err;

  modport master (
    output stall, branch, jump, call, ret, imm,
    input  PC, sp, ras_full, ras_empty, ras_err
  );

  modport slave (
    input  stall, branch, jump, call, ret, imm,
    output PC, sp, ras_full, ras_empty, ras_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for the fetch stage. Each rising
//               edge performs one action, priority highest first:
//               stall > ret > call > jump > branch > increment.
//               Calls push PC+1 onto an internal return-address stack; ret
//               pops it. Overflow/underflow set a sticky ras_err.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - pc_sequencer_if.slave (controls, imm, PC, stack status)
// Options     : PCSEQ_TRAP_EN - when defined, a faulting call/ret redirects
//               the PC to TRAP_VEC instead of its normal target.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int              PC_W      = 8,
  parameter int              IMM_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(8'hF0)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  pc_sequencer_if.slave      bus
);

  localparam int              SP_W   = $clog2(RAS_DEPTH + 1);
  // Stack is sized to the full sp index range so sp can index it directly;
  // entries at or above RAS_DEPTH are never written.
  localparam int              SLOTS  = 1 << SP_W;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(RAS_DEPTH);

`ifdef PCSEQ_TRAP_EN
  localparam logic TRAP_ON = 1'b1;
`else
  localparam logic TRAP_ON = 1'b0;
`endif

  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic            r_err;
  logic [PC_W-1:0] r_stack [SLOTS];

  logic [PC_W-1:0] w_pc_next;
  logic [SP_W-1:0] w_sp_next;
  logic            w_err_next;
  logic            w_push;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_imm_zext;
  logic [PC_W-1:0] w_imm_sext;

  generate
    if (PC_W > IMM_W) begin : g_ext_wide
      assign w_imm_zext = {{(PC_W-IMM_W){1'b0}}, bus.imm};
      assign w_imm_sext = {{(PC_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    end else begin : g_ext_same
      assign w_imm_zext = bus.imm;
      assign w_imm_sext = bus.imm;
    end
  endgenerate

  // Wraps modulo 2^PC_W, so PC all-ones pushes a return address of 0.
  assign w_pc_inc = r_pc + PC_W'(1);

  always_comb begin
    w_pc_next  = w_pc_inc;
    w_sp_next  = r_sp;
    w_err_next = r_err;
    w_push     = 1'b0;
    if (bus.stall) begin
      w_pc_next = r_pc;
    end else if (bus.ret) begin
      if (r_sp != '0) begin
        w_pc_next = r_stack[r_sp - SP_W'(1)];
        w_sp_next = r_sp - SP_W'(1);
      end else begin
        w_err_next = 1'b1;
        w_pc_next  = TRAP_ON ? TRAP_VEC : w_pc_inc;
      end
    end else if (bus.call) begin
      if (r_sp != SP_MAX) begin
        w_push    = 1'b1;
        w_sp_next = r_sp + SP_W'(1);
        w_pc_next = w_imm_zext;
      end else begin
        w_err_next = 1'b1;
        w_pc_next  = TRAP_ON ? TRAP_VEC : w_imm_zext;
      end
    end else if (bus.jump) begin
      w_pc_next = w_imm_zext;
    end else if (bus.branch) begin
      w_pc_next = r_pc + w_imm_sext + PC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_VEC;
      r_sp  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_sp  <= w_sp_next;
      r_err <= w_err_next;
    end
  end

  // Stack contents need no reset; only sp decides which entries are valid.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_stack[r_sp] <= w_pc_inc;
    end
  end

  assign bus.PC        = r_pc;
  assign bus.sp        = r_sp;
  assign bus.ras_full  = (r_sp == SP_MAX);
  assign bus.ras_empty = (r_sp == '0);
  assign bus.ras_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer with default
//               parameters (PC_W=8, IMM_W=8, RAS_DEPTH=4, RESET_VEC=0).
//               Expected fault targets follow PCSEQ_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_sequencer_if #(.PC_W(8), .IMM_W(8), .RAS_DEPTH(4)) bus ();

  pc_sequencer #(
    .PC_W(8), .IMM_W(8), .RAS_DEPTH(4), .RESET_VEC(8'h00), .TRAP_VEC(8'hF0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef PCSEQ_TRAP_EN
  localparam logic [7:0] OVF_PC = 8'hF0;
  localparam logic [7:0] UNF_PC = 8'hF0;
  localparam logic [7:0] END_PC = 8'hFA;
`else
  localparam logic [7:0] OVF_PC = 8'h60;
  localparam logic [7:0] UNF_PC = 8'h21;
  localparam logic [7:0] END_PC = 8'h2B;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic j,
                       input logic c, input logic r, input logic [7:0] im);
    bus.stall  = s;
    bus.branch = b;
    bus.jump   = j;
    bus.call   = c;
    bus.ret    = r;
    bus.imm    = im;
  endtask

  // One edge with the given controls; outputs sampled 1 time unit later.
  task automatic step(input logic s, input logic b, input logic j,
                      input logic c, input logic r, input logic [7:0] im);
    drive(s, b, j, c, r, im);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 8'h00);
    #2;
    check("rst_pc",    32'(bus.PC), 32'h00);
    check("rst_sp",    32'(bus.sp), 32'd0);
    check("rst_empty", 32'(bus.ras_empty), 32'd1);
    check("rst_full",  32'(bus.ras_full), 32'd0);
    check("rst_err",   32'(bus.ras_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 8'h00);
      check("inc_pc", 32'(bus.PC), 32'(i));
    end
    step(0, 0, 1, 0, 0, 8'hFE); check("jump_fe",  32'(bus.PC), 32'hFE);
    step(0, 0, 0, 0, 0, 8'h00); check("inc_ff",   32'(bus.PC), 32'hFF);
    step(0, 0, 0, 0, 0, 8'h00); check("wrap_00",  32'(bus.PC), 32'h00);
    check("wrap_err", 32'(bus.ras_err), 32'd0);

    step(0, 0, 1, 0, 0, 8'h0A); check("jump_0a",  32'(bus.PC), 32'h0A);
    step(0, 1, 0, 0, 0, 8'hFB); check("br_neg",   32'(bus.PC), 32'h06);
    step(0, 1, 0, 0, 0, 8'h05); check("br_pos",   32'(bus.PC), 32'h0C);
    step(0, 1, 1, 0, 0, 8'h30); check("jump_win", 32'(bus.PC), 32'h30);

    step(0, 0, 1, 0, 0, 8'h12);
    step(0, 0, 0, 1, 0, 8'h40);
    check("call1_pc", 32'(bus.PC), 32'h40);
    check("call1_sp", 32'(bus.sp), 32'd1);
    check("call1_empty", 32'(bus.ras_empty), 32'd0);
    step(0, 0, 0, 1, 0, 8'h50);
    check("call2_pc", 32'(bus.PC), 32'h50);
    check("call2_sp", 32'(bus.sp), 32'd2);
    step(0, 0, 0, 0, 1, 8'h00);
    check("ret1_pc", 32'(bus.PC), 32'h41);
    check("ret1_sp", 32'(bus.sp), 32'd1);
    step(0, 0, 0, 0, 1, 8'h00);
    check("ret2_pc", 32'(bus.PC), 32'h13);
    check("ret2_sp", 32'(bus.sp), 32'd0);
    check("ret2_empty", 32'(bus.ras_empty), 32'd1);

    // call+ret at sp=1: ret wins and returns to 0x14
    step(0, 0, 0, 1, 0, 8'h40);
    step(0, 0, 0, 1, 1, 8'h55);
    check("cr_pc", 32'(bus.PC), 32'h14);
    check("cr_sp", 32'(bus.sp), 32'd0);

    // return address wraps: call from 0xFF pushes 0x00
    step(0, 0, 1, 0, 0, 8'hFF);
    step(0, 0, 0, 1, 0, 8'h30);
    step(0, 0, 0, 0, 1, 8'h00);
    check("wrapret_pc", 32'(bus.PC), 32'h00);

    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 0, 8'(i));
    check("full_sp",   32'(bus.sp), 32'd4);
    check("full_flag", 32'(bus.ras_full), 32'd1);
    check("full_err",  32'(bus.ras_err), 32'd0);
    step(0, 0, 0, 1, 0, 8'h60);
    check("ovf_pc",  32'(bus.PC), 32'(OVF_PC));
    check("ovf_sp",  32'(bus.sp), 32'd4);
    check("ovf_err", 32'(bus.ras_err), 32'd1);

    // reset pulse between edges clears the stack and the error
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    check("rst2_err", 32'(bus.ras_err), 32'd0);
    step(0, 0, 1, 0, 0, 8'h20);
    step(0, 0, 0, 0, 1, 8'h00);
    check("unf_pc",  32'(bus.PC), 32'(UNF_PC));
    check("unf_err", 32'(bus.ras_err), 32'd1);
    check("unf_sp",  32'(bus.sp), 32'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 8'h00);
    check("sticky_err", 32'(bus.ras_err), 32'd1);
    check("sticky_pc",  32'(bus.PC), 32'(END_PC));

    step(0, 0, 0, 1, 0, 8'h70);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0, 8'h77);
      check("stall_pc", 32'(bus.PC), 32'h70);
      check("stall_sp", 32'(bus.sp), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_pc",  32'(bus.PC), 32'h00);
    check("async_sp",  32'(bus.sp), 32'd0);
    check("async_err", 32'(bus.ras_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
